// File: rtl/weighted_round_robin_arbiter_if.sv
// Handshake bundle between requesters and the weighted round-robin arbiter.
// The master side drives requests, weights and grant_ready; the slave side drives the grant.
interface weighted_round_robin_arbiter_if #(
  parameter int SIZE         = 4,
  parameter int WEIGHT_WIDTH = 4,
  localparam int IDX_W       = (SIZE > 1) ? $clog2(SIZE) : 1
);
  logic [SIZE-1:0]              requests;
  logic [SIZE*WEIGHT_WIDTH-1:0] weights;
  logic [SIZE-1:0]              grant;
  logic [IDX_W-1:0]             grant_index;
  logic                         grant_valid;
  logic                         grant_ready;

  modport master (
    output requests, weights, grant_ready,
    input  grant, grant_index, grant_valid
  );

  modport slave (
    input  requests, weights, grant_ready,
    output grant, grant_index, grant_valid
  );
endinterface

// File: rtl/barrel_rotator_left.sv
// Rotates a SIZE-bit vector left by i_shift positions, wrapping modulo SIZE.
// i_shift must stay below SIZE.
module barrel_rotator_left #(
  parameter int SIZE  = 4,
  parameter int IDX_W = 2
) (
  input  logic [SIZE-1:0]  i_data,
  input  logic [IDX_W-1:0] i_shift,
  output logic [SIZE-1:0]  o_data
);
  logic [2*SIZE-1:0] w_doubled;

  assign w_doubled = {i_data, i_data} << i_shift;
  assign o_data    = w_doubled[2*SIZE-1:SIZE];
endmodule

// File: rtl/barrel_rotator_right.sv
// Rotates a SIZE-bit vector right by i_shift positions, wrapping modulo SIZE.
// i_shift must stay below SIZE.
module barrel_rotator_right #(
  parameter int SIZE  = 4,
  parameter int IDX_W = 2
) (
  input  logic [SIZE-1:0]  i_data,
  input  logic [IDX_W-1:0] i_shift,
  output logic [SIZE-1:0]  o_data
);
  logic [2*SIZE-1:0] w_doubled;

  assign w_doubled = {i_data, i_data} >> i_shift;
  assign o_data    = w_doubled[SIZE-1:0];
endmodule

// File: rtl/static_priority_arbiter.sv
// Fixed-priority pick: the lowest-numbered active request wins.
module static_priority_arbiter #(
  parameter int SIZE  = 4,
  parameter int IDX_W = 2
) (
  input  logic [SIZE-1:0]  i_requests,
  output logic [SIZE-1:0]  o_grant,
  output logic [IDX_W-1:0] o_index,
  output logic             o_found
);
  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_found = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (i_requests[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_index    = IDX_W'(i);
        o_found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/weighted_round_robin_selector.sv
// Cyclic first-request search starting at i_pointer, wrapping at SIZE-1 back to 0.
module weighted_round_robin_selector #(
  parameter int SIZE  = 4,
  parameter int IDX_W = 2
) (
  input  logic [SIZE-1:0]  i_requests,
  input  logic [IDX_W-1:0] i_pointer,
  output logic [SIZE-1:0]  o_grant,
  output logic [IDX_W-1:0] o_index,
  output logic             o_found
);
  localparam logic [IDX_W:0] SIZE_W = SIZE[IDX_W:0];

  logic [SIZE-1:0]  w_rotated;
  logic [SIZE-1:0]  w_rotGrant;
  logic [IDX_W-1:0] w_rotIndex;
  logic [IDX_W:0]   w_sum;

  // Bring the pointer channel to bit 0, pick the lowest, then undo the rotation.
  barrel_rotator_right #(.SIZE(SIZE), .IDX_W(IDX_W)) u_rotIn (
    .i_data (i_requests),
    .i_shift(i_pointer),
    .o_data (w_rotated)
  );

  static_priority_arbiter #(.SIZE(SIZE), .IDX_W(IDX_W)) u_prio (
    .i_requests(w_rotated),
    .o_grant   (w_rotGrant),
    .o_index   (w_rotIndex),
    .o_found   (o_found)
  );

  barrel_rotator_left #(.SIZE(SIZE), .IDX_W(IDX_W)) u_rotOut (
    .i_data (w_rotGrant),
    .i_shift(i_pointer),
    .o_data (o_grant)
  );

  assign w_sum   = {1'b0, i_pointer} + {1'b0, w_rotIndex};
  assign o_index = (w_sum >= SIZE_W) ? IDX_W'(w_sum - SIZE_W) : w_sum[IDX_W-1:0];
endmodule

// File: rtl/weighted_round_robin_arbiter.sv
// Work-conserving weighted round-robin arbiter with a registered, handshaked grant.
// A channel keeps the grant for up to max(weight,1) accepted beats while it keeps requesting.
module weighted_round_robin_arbiter #(
  parameter int SIZE         = 4,
  parameter int WEIGHT_WIDTH = 4,
  localparam int IDX_W       = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SIZE-1:0]              requests,
  input  logic [SIZE*WEIGHT_WIDTH-1:0] weights,
  output logic [SIZE-1:0]              grant,
  output logic [IDX_W-1:0]             grant_index,
  output logic                         grant_valid,
  input  logic                         grant_ready
);
  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);

  state_t                  r_state, w_state;
  logic [IDX_W-1:0]        r_ptr, w_ptr;
  logic [WEIGHT_WIDTH-1:0] r_credit, w_credit;
  logic [SIZE-1:0]         r_grant, w_grant;
  logic [IDX_W-1:0]        r_index, w_index;
  logic                    r_valid, w_valid;

  logic [IDX_W-1:0]        w_curNext;
  logic [IDX_W-1:0]        w_selPtr;
  logic [SIZE-1:0]         w_selGrant;
  logic [IDX_W-1:0]        w_selIndex;
  logic                    w_found;
  logic [WEIGHT_WIDTH-1:0] w_winWeight;
  logic [WEIGHT_WIDTH-1:0] w_loadCredit;
  logic [WEIGHT_WIDTH-1:0] w_creditDec;

  // While granting, the search starts just past the served channel so it ends up lowest priority.
  assign w_curNext = (r_index == LAST) ? '0 : r_index + IDX_W'(1);
  assign w_selPtr  = (r_state == S_GRANT) ? w_curNext : r_ptr;

  weighted_round_robin_selector #(.SIZE(SIZE), .IDX_W(IDX_W)) u_selector (
    .i_requests(requests),
    .i_pointer (w_selPtr),
    .o_grant   (w_selGrant),
    .o_index   (w_selIndex),
    .o_found   (w_found)
  );

  always_comb begin
    w_winWeight = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (w_selIndex == IDX_W'(i)) w_winWeight = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  assign w_loadCredit = (w_winWeight == '0) ? WEIGHT_WIDTH'(1) : w_winWeight;
  assign w_creditDec  = r_credit - WEIGHT_WIDTH'(1);

  always_comb begin
    w_state  = r_state;
    w_ptr    = r_ptr;
    w_credit = r_credit;
    w_grant  = r_grant;
    w_index  = r_index;
    w_valid  = r_valid;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state  = S_GRANT;
          w_grant  = w_selGrant;
          w_index  = w_selIndex;
          w_valid  = 1'b1;
          w_credit = w_loadCredit;
        end
      end
      S_GRANT: begin
        // Without a handshake the offered grant is held untouched.
        if (grant_ready) begin
          if ((w_creditDec != '0) && requests[r_index]) begin
            w_credit = w_creditDec;
          end else begin
            w_ptr = w_curNext;
            if (w_found) begin
              w_grant  = w_selGrant;
              w_index  = w_selIndex;
              w_credit = w_loadCredit;
            end else begin
              w_state  = S_IDLE;
              w_grant  = '0;
              w_index  = '0;
              w_valid  = 1'b0;
              w_credit = '0;
            end
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_credit <= '0;
      r_grant  <= '0;
      r_index  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_ptr    <= w_ptr;
      r_credit <= w_credit;
      r_grant  <= w_grant;
      r_index  <= w_index;
      r_valid  <= w_valid;
    end
  end

  assign grant       = r_grant;
  assign grant_index = r_index;
  assign grant_valid = r_valid;
endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Randomized scoreboard bench for the weighted round-robin arbiter (SIZE=4 and SIZE=3 instances).
// A burst-level reference model predicts each registered grant; a monitor compares after every edge.
module tb_weighted_round_robin_arbiter;
  localparam int SIZE = 4;
  localparam int WW   = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  weighted_round_robin_arbiter_if #(.SIZE(SIZE), .WEIGHT_WIDTH(WW)) bus4 ();

  weighted_round_robin_arbiter #(.SIZE(SIZE), .WEIGHT_WIDTH(WW)) dut4 (
    .clock      (clock),
    .reset      (reset),
    .requests   (bus4.requests),
    .weights    (bus4.weights),
    .grant      (bus4.grant),
    .grant_index(bus4.grant_index),
    .grant_valid(bus4.grant_valid),
    .grant_ready(bus4.grant_ready)
  );

  logic [2:0]  req3;
  logic [11:0] wts3;
  logic        rdy3;
  logic [2:0]  grant3;
  logic [1:0]  idx3;
  logic        valid3;

  weighted_round_robin_arbiter #(.SIZE(3), .WEIGHT_WIDTH(WW)) dut3 (
    .clock      (clock),
    .reset      (reset),
    .requests   (req3),
    .weights    (wts3),
    .grant      (grant3),
    .grant_index(idx3),
    .grant_valid(valid3),
    .grant_ready(rdy3)
  );

  typedef struct {
    bit valid;
    int owner;
    int used;
    int limit;
    int ptr;
  } model_t;

  typedef struct {
    bit valid;
    int owner;
  } exp_t;

  exp_t   q4[$];
  exp_t   q3[$];
  model_t m4;
  model_t m3;
  int     total = 0;
  int     bad   = 0;

  function automatic int search(input int sz, input logic [3:0] req, input int ptr);
    for (int k = 0; k < sz; k++) begin
      if (req[(ptr + k) % sz]) return (ptr + k) % sz;
    end
    return -1;
  endfunction

  function automatic void loadOwner(inout model_t m, input int w, input logic [15:0] wts);
    int lim;
    lim     = int'(wts[w*4 +: 4]);
    m.valid = 1'b1;
    m.owner = w;
    m.used  = 0;
    m.limit = (lim == 0) ? 1 : lim;
  endfunction

  // Model state is what the registered outputs show after the next rising edge.
  function automatic void modelStep(inout model_t m, input int sz, input logic [3:0] req,
                                    input logic [15:0] wts, input bit rdy, input bit rst);
    int w;
    if (rst) begin
      m.valid = 1'b0;
      m.owner = 0;
      m.used  = 0;
      m.limit = 0;
      m.ptr   = 0;
      return;
    end
    if (!m.valid) begin
      w = search(sz, req, m.ptr);
      if (w >= 0) loadOwner(m, w, wts);
    end else if (rdy) begin
      m.used++;
      if (!(m.used < m.limit && req[m.owner])) begin
        m.ptr = (m.owner + 1) % sz;
        w = search(sz, req, m.ptr);
        if (w >= 0) loadOwner(m, w, wts);
        else m.valid = 1'b0;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int cyc);
    logic [3:0]  r;
    logic [15:0] w;
    bit          rdy;
    bit          rst;
    exp_t        e;
    rst = (cyc == 300);
    if (cyc < 10) begin
      r = 4'h0; w = 16'h1111; rdy = 1'b1;
    end else if (cyc < 30) begin
      r = 4'hF; w = 16'h1111; rdy = 1'b1;
    end else if (cyc < 58) begin
      r = 4'hF; w = 16'h1213; rdy = 1'b1;
    end else if (cyc < 68) begin
      r = 4'($urandom); w = 16'($urandom); rdy = 1'b0;
    end else begin
      r   = (($urandom % 3) == 0) ? 4'h0 : 4'($urandom);
      w   = 16'($urandom);
      rdy = (($urandom % 4) != 0);
    end
    reset             = rst;
    bus4.requests     = r;
    bus4.weights      = w;
    bus4.grant_ready  = rdy;
    if (cyc < 200) begin
      req3 = 3'b111; wts3 = 12'h000; rdy3 = 1'b1;
    end else begin
      req3 = 3'($urandom); wts3 = 12'($urandom); rdy3 = (($urandom % 2) == 0);
    end
    if (rst) begin
      #1;
      checkOutput("rst_valid4", int'(bus4.grant_valid), 0);
      checkOutput("rst_grant4", int'(bus4.grant), 0);
      checkOutput("rst_valid3", int'(valid3), 0);
      checkOutput("rst_grant3", int'(grant3), 0);
    end
    modelStep(m4, 4, r, w, rdy, rst);
    e.valid = m4.valid; e.owner = m4.owner;
    q4.push_back(e);
    modelStep(m3, 3, {1'b0, req3}, {4'h0, wts3}, rdy3, rst);
    e.valid = m3.valid; e.owner = m3.owner;
    q3.push_back(e);
  endtask

  // Monitor: pop one expectation per instance after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        checkOutput("valid4", int'(bus4.grant_valid), int'(e.valid));
        if (e.valid) begin
          checkOutput("grant4", int'(bus4.grant), 1 << e.owner);
          checkOutput("index4", int'(bus4.grant_index), e.owner);
        end else begin
          checkOutput("idle_grant4", int'(bus4.grant), 0);
        end
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        checkOutput("valid3", int'(valid3), int'(e.valid));
        if (e.valid) begin
          checkOutput("grant3", int'(grant3), 1 << e.owner);
          checkOutput("index3", int'(idx3), e.owner);
        end else begin
          checkOutput("idle_grant3", int'(grant3), 0);
        end
      end
    end
  end

  initial begin
    reset            = 1'b1;
    bus4.requests    = '0;
    bus4.weights     = '0;
    bus4.grant_ready = 1'b0;
    req3             = '0;
    wts3             = '0;
    rdy3             = 1'b0;
    m4 = '{valid: 1'b0, owner: 0, used: 0, limit: 0, ptr: 0};
    m3 = '{valid: 1'b0, owner: 0, used: 0, limit: 0, ptr: 0};
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_valid4", int'(bus4.grant_valid), 0);
    checkOutput("reset_grant4", int'(bus4.grant), 0);
    checkOutput("reset_index4", int'(bus4.grant_index), 0);
    checkOutput("reset_valid3", int'(valid3), 0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      applyStimulus(cyc);
    end
    @(posedge clock);
    #2;
    checkOutput("queue4_drained", q4.size(), 0);
    checkOutput("queue3_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/weighted_round_robin_arbiter.md
# weighted_round_robin_arbiter

Work-conserving weighted round-robin arbiter with a registered, handshaked grant.
- Pointer advances only past the channel actually served, not every cycle.
- Each channel may hold the grant for up to its programmed weight of accepted beats while it keeps requesting.
- Sits in front of shared resources (buses, memory ports, FIFO write sides) where the consumer applies back-pressure and channels need configurable bandwidth shares.

## Interface
Parameters:
- SIZE, 4, number of request channels (≥1, need not be a power of two)
- WEIGHT_WIDTH, 4, bits per channel weight

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- requests  input  SIZE  per-channel request level
- weights  input  SIZE*WEIGHT_WIDTH  channel i weight at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; value 0 treated as 1
- grant  output  SIZE  one-hot registered grant, all-zero when idle
- grant_index  output  max(CLOG2(SIZE),1)  binary index of granted channel
- grant_valid  output  1  a grant is being offered
- grant_ready  input  1  consumer accepts current beat

## Operation
State: FSM {IDLE, GRANT}, pointer (index), credit (WEIGHT_WIDTH bits), registered grant/grant_index.
- Selection function: first channel with request set, searching cyclically from pointer upward, wrapping at SIZE-1 → 0 (not at 2^n).
- IDLE:
  - No request: stay.
  - Any request: register winner, load credit = max(weight[winner],1), go GRANT.
- GRANT, no handshake (grant_valid & !grant_ready): hold grant, grant_index, credit unchanged regardless of requests (grant is sticky until accepted).
- GRANT, handshake: credit_next = credit − 1.
  - credit_next > 0 and requests[current]=1: keep same grant, credit = credit_next.
  - Otherwise: pointer = (current+1) mod SIZE. Select from that new pointer using the current-cycle requests, which includes the current channel as the lowest priority.
  - Winner found: register it, reload credit, stay GRANT (no bubble).
  - No winner: go IDLE, clear grant.
- Weights are sampled only when a grant is loaded; changes mid-burst take effect at the next load.
- SIZE=1: channel 0 always wins; pointer stays 0.

## Timing
- Reset values: grant=0, grant_index=0, grant_valid=0, pointer=0, credit=0, state=IDLE.
- Request-to-grant latency: 1 cycle from IDLE (request sampled at edge N, grant_valid high after edge N).
- Back-to-back: accepted beat at edge N with further eligible requests → new grant visible after edge N, so grant_valid stays high with no gap.
- Maximum consecutive beats to one channel under contention: max(weight,1).
- Reset asserted mid-burst: all state returns to reset values immediately (asynchronously). The first grant after deassertion searches from pointer 0.
- grant, grant_index and grant_valid are pure register outputs with no combinational path from inputs.
- grant_valid == |grant at all times.

## Structure
- CLOG2 comes from common.vh. The index width expression is the only derived constant; no new package.
- One natural combinational sub-module: weighted_round_robin_selector (requests, pointer → one-hot winner, index, found). Built from barrel_rotator_left, static_priority_arbiter and barrel_rotator_right with modulo-SIZE rotation.
- Rest (FSM, credit, pointer, output registers) lives in the top module.

## Test plan
- Reset, then requests=4'b0000 for 10 cycles → grant_valid=0, grant=0 throughout. Assert reset mid-grant → outputs 0 immediately.
- SIZE=4, all weights 1, requests=4'b1111, grant_ready=1 → grant sequence 0001,0010,0100,1000,0001… with no idle cycles.
- Weights {3,1,2,1} (ch0..3), requests=4'b1111, ready=1 → channel sequence 0,0,0,1,2,2,3, repeating.
- Channel 2 granted with weight 4, requests drop to 4'b0001 after second accepted beat → next grant is ch0, pointer=3, no bubble.
- grant=0100 with grant_ready=0 for 5 cycles while requests change → grant, grant_index=2 and credit frozen; first ready beat decrements credit.
- SIZE=3, weight 0 on all channels, requests=3'b111 → treated as weight 1. Order 0,1,2,0, with wrap 2→0 and never index 3.
